// File: rtl/rptr_empty_lvl_pkg.sv
// Shared FIFO constants and pointer helpers, common to the read- and write-side pointer blocks.
package rptr_empty_lvl_pkg;

  localparam int unsigned DefAddrSize = 4;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/rptr_empty_lvl_if.sv
// Read-side FIFO pointer bus: requests and synced write pointer in, address/status out.
interface rptr_empty_lvl_if
  import rptr_empty_lvl_pkg::*;
#(
  parameter int unsigned ADDRSIZE = DefAddrSize
);

  logic                rinc;
  logic                rflush;
  logic                rclr_err;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                rerr_underflow;

  modport master (
    output rinc, rflush, rclr_err, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel, rerr_underflow
  );

  modport slave (
    input  rinc, rflush, rclr_err, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel, rerr_underflow
  );

endinterface

// File: rtl/rptr_empty_lvl_gray2bin.sv
// Parametrised Gray-to-binary converter, shared by both FIFO pointer domains.
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side FIFO pointer: Gray/binary read pointer, registered empty/almost-empty,
// fill level and sticky underflow flag.
module rptr_empty_lvl
  import rptr_empty_lvl_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = DefAddrSize,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  rptr_empty_lvl_if.slave       bus
);

  localparam int unsigned PtrW = ptr_w(ADDRSIZE);

  if (AEMPTY_THRESH >= (2 ** ADDRSIZE)) begin : g_bad_thresh
    $error("AEMPTY_THRESH must be below 2**ADDRSIZE");
  end

  logic [PtrW-1:0] r_rbin;
  logic [PtrW-1:0] r_rptr;
  logic            r_rempty;
  logic            r_raempty;
  logic [PtrW-1:0] r_rlevel;
  logic            r_uflow;

  logic [PtrW-1:0] w_wbin;
  logic [PtrW-1:0] w_rbinnext;
  logic [PtrW-1:0] w_rgraynext;
  logic [PtrW-1:0] w_levelnext;
  logic            w_rd_fire;
  logic            w_uflow_set;
  logic            w_uflow_d;

  gray2bin #(
    .WIDTH (PtrW)
  ) u_wptr_g2b (
    .i_gray (bus.rq2_wptr),
    .o_bin  (w_wbin)
  );

  always_comb begin
    w_rd_fire   = bus.rinc & ~r_rempty;
    // Flush jumps straight to the write pointer, so it also suppresses underflow.
    w_uflow_set = bus.rinc & r_rempty & ~bus.rflush;
    w_uflow_d   = w_uflow_set | (r_uflow & ~bus.rclr_err);
    if (bus.rflush) begin
      w_rbinnext = w_wbin;
    end else begin
      w_rbinnext = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_fire};
    end
    w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
    w_levelnext = w_wbin - w_rbinnext;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rlevel  <= '0;
      r_uflow   <= 1'b0;
    end else begin
      r_rbin    <= w_rbinnext;
      r_rptr    <= w_rgraynext;
      r_rempty  <= (w_rgraynext == bus.rq2_wptr);
      r_raempty <= (w_levelnext <= PtrW'(AEMPTY_THRESH));
      r_rlevel  <= w_levelnext;
      r_uflow   <= w_uflow_d;
    end
  end

  assign bus.raddr          = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr           = r_rptr;
  assign bus.rempty         = r_rempty;
  assign bus.raempty        = r_raempty;
  assign bus.rlevel         = r_rlevel;
  assign bus.rerr_underflow = r_uflow;

endmodule

// File: doc/rptr_empty_lvl.md
RPTR_EMPTY_LVL -- requirements
Module: rptr_empty_lvl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
REQ-002 SHALL have parameter AEMPTY_THRESH, default 2: almost-empty asserts when level <= this value; legal range 0..2^ADDRSIZE-1.
REQ-003 SHALL have port rclk, input, 1 bit: read-domain clock; the only clock.
REQ-004 SHALL have port rrst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rinc, input, 1 bit: read request.
REQ-006 SHALL have port rflush, input, 1 bit: discard all unread data.
REQ-007 SHALL have port rclr_err, input, 1 bit: clear the sticky underflow flag.
REQ-008 SHALL have port rq2_wptr, input, ADDRSIZE+1 bits: Gray write pointer, already synchronized into rclk.
REQ-009 SHALL have port raddr, output, ADDRSIZE bits: binary RAM read address.
REQ-010 SHALL have port rptr, output, ADDRSIZE+1 bits: registered Gray read pointer for the write-side synchronizer.
REQ-011 SHALL have port rempty, output, 1 bit: FIFO empty.
REQ-012 SHALL have port raempty, output, 1 bit: FIFO almost empty.
REQ-013 SHALL have port rlevel, output, ADDRSIZE+1 bits: read-side fill level, 0..2^ADDRSIZE.
REQ-014 SHALL have port rerr_underflow, output, 1 bit: sticky underflow error.

Function
REQ-015 SHALL convert rq2_wptr combinationally to binary wbin_s (bit i = XOR of Gray bits ADDRSIZE..i).
REQ-016 SHALL compute the next binary pointer rbinnext: wbin_s when rflush=1; otherwise rbin + (rinc & ~rempty).
REQ-017 SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext, and register rbin <= rbinnext and rptr <= rgraynext every rclk.
REQ-018 SHALL drive raddr = rbin[ADDRSIZE-1:0] with no added latency.
REQ-019 SHALL register rempty <= (rgraynext == rq2_wptr), giving one-cycle latency; the read that empties the FIFO raises rempty on the next edge.
REQ-020 SHALL register rlevel <= (wbin_s - rbinnext) modulo 2^(ADDRSIZE+1).
REQ-021 SHALL register raempty <= (that same next level <= AEMPTY_THRESH), so raempty=1 whenever rempty=1.
REQ-022 SHALL wrap pointers modulo 2^(ADDRSIZE+1) with no special case; the level SHALL stay correct across the wrap.
REQ-023 SHALL ignore rinc when rempty=1 (pointer holds), and set rerr_underflow on the next edge.
REQ-024 SHALL keep rerr_underflow set until rclr_err=1; if a set and a clear occur in the same cycle, set SHALL win.
REQ-025 SHALL give rflush priority over rinc when both are high; the cycle after, rempty=1, raempty=1, rlevel=0, and no underflow is flagged.
REQ-026 SHALL let rq2_wptr advance while rempty=1; rempty SHALL deassert on the first edge where rgraynext != rq2_wptr.

Reset
REQ-027 SHALL, while rrst_n=0 (asynchronous): rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, rerr_underflow=0.
REQ-028 SHALL, when reset is asserted mid-operation, abort any in-flight read and not flag underflow; normal operation SHALL resume on the first rclk edge after reset release.

Structure
REQ-029 SHALL keep shared constants (default ADDRSIZE, Gray/binary width formula) in the FIFO common package/header, which the write-side block also uses.
REQ-030 SHALL place the Gray-to-binary conversion in one parametrised sub-module, gray2bin (width parameter), for reuse by the write side.
REQ-031 SHALL reject AEMPTY_THRESH >= 2^ADDRSIZE at elaboration.

Verification (ADDRSIZE=4, AEMPTY_THRESH=2)
REQ-032 SHALL cover reset then idle: rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0.
REQ-033 SHALL cover rq2_wptr = Gray(5), no rinc: next cycle rempty=0, raempty=0, rlevel=5; then 3 reads give rlevel 4,3,2, with raempty=1 at level 2; 2 more reads give rempty=1 and raddr=5.
REQ-034 SHALL cover wrap: rbin=30, wbin=2, level=4; 4 reads give raddr 14,15,0,1, rptr wrapping to Gray(0), and rempty=1.
REQ-035 SHALL cover rinc held for 2 cycles while empty: rbin unchanged and rerr_underflow=1 and sticky; rclr_err alone clears it; rclr_err together with a new underflow leaves it at 1.
REQ-036 SHALL cover level 7 with rflush and rinc high in the same cycle: next cycle rbin=wbin, rempty=1, rlevel=0, rerr_underflow=0.
REQ-037 SHALL cover full FIFO (wbin = rbin+16): rlevel=16, raempty=0; rrst_n pulsed mid-read gives all outputs at reset values immediately, without waiting for an rclk edge.
